// File: rtl/load_writeback_unit.sv
// Load/write-back stage of the multicycle MIPS CPU: issues data-memory reads,
// latches the MDR, aligns/extends/merges loads and drives the register-file write port.
module load_writeback_unit #(
  parameter int ADDR_W   = 32,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic [31:0]       instr,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rt_data,
  input  logic [31:0]       link_addr,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              stall,
  output logic              addr_error,
  output logic              RegWrite,
  output logic [4:0]        writeR,
  output logic [31:0]       writedata
);

  localparam logic [2:0] ST_FETCH = 3'b000;
  localparam logic [2:0] ST_MEM   = 3'b011;
  localparam logic [2:0] ST_WB    = 3'b100;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LWL    = 6'b100010;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_LWR    = 6'b100110;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [4:0] LINK_R = 5'(LINK_REG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } lsu_state_t;

  lsu_state_t  fsm_r;
  logic [31:0] mdr_r;
  logic        addr_error_r;
  logic        bad_load_r;
  logic [4:0]  dest_hold_r;
  logic [31:0] data_hold_r;

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [1:0]  k_s;
  logic        is_load_s;
  logic        misaligned_s;
  logic        issue_s;
  logic        req_active_s;
  logic [3:0]  be_s;
  logic        wr_en_s;
  logic [4:0]  wr_dest_s;
  logic [31:0] wr_data_s;
  logic        in_wb_s;
  logic        unused_bits_s;

  assign opcode_s      = instr[31:26];
  assign funct_s       = instr[5:0];
  assign rt_s          = instr[20:16];
  assign rd_s          = instr[15:11];
  assign k_s           = alu_result[1:0];
  assign in_wb_s       = (state == ST_WB);
  assign unused_bits_s = ^{instr[25:21], instr[10:6]};

  // Extract, extend or merge the latched word according to the load type.
  function automatic logic [31:0] align_load(input logic [5:0]  op,
                                             input logic [1:0]  k,
                                             input logic [31:0] mdr,
                                             input logic [31:0] rt);
    logic [31:0] byte_w;
    logic [15:0] half_w;
    logic [5:0]  sh_mem;
    logic [5:0]  sh_keep;
    logic [31:0] res;
    byte_w  = mdr >> {k, 3'b000};
    half_w  = k[1] ? mdr[31:16] : mdr[15:0];
    sh_mem  = 6'd0;
    sh_keep = 6'd0;
    case (op)
      OP_LB:   res = {{24{byte_w[7]}}, byte_w[7:0]};
      OP_LBU:  res = {24'd0, byte_w[7:0]};
      OP_LH:   res = {{16{half_w[15]}}, half_w};
      OP_LHU:  res = {16'd0, half_w};
      OP_LWL: begin
        sh_mem  = {1'b0, ~k, 3'b000};
        sh_keep = {({1'b0, k} + 3'd1), 3'b000};
        res     = (mdr << sh_mem) | (rt & (32'hFFFF_FFFF >> sh_keep));
      end
      OP_LWR: begin
        sh_mem = {1'b0, k, 3'b000};
        res    = (mdr >> sh_mem) | (rt & ~(32'hFFFF_FFFF >> sh_mem));
      end
      default: res = mdr;
    endcase
    return res;
  endfunction

  // Load classification, alignment check and lane enables.
  always_comb begin
    is_load_s    = 1'b0;
    misaligned_s = 1'b0;
    be_s         = 4'b0000;
    case (opcode_s)
      OP_LB, OP_LBU: begin
        is_load_s = 1'b1;
        be_s      = 4'b0001 << k_s;
      end
      OP_LH, OP_LHU: begin
        is_load_s    = 1'b1;
        misaligned_s = k_s[0];
        be_s         = k_s[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        is_load_s    = 1'b1;
        misaligned_s = (k_s != 2'b00);
        be_s         = 4'b1111;
      end
      OP_LWL, OP_LWR: begin
        is_load_s = 1'b1;
        be_s      = 4'b1111;
      end
      default: begin
        is_load_s = 1'b0;
      end
    endcase
  end

  // The read goes out in the first MEMORY_ACCESS cycle so a zero-wait load needs no stall.
  assign issue_s        = (state == ST_MEM) && (fsm_r == IDLE) && is_load_s && !misaligned_s;
  assign req_active_s   = issue_s || (fsm_r == REQ);
  assign mem_read       = req_active_s;
  assign stall          = req_active_s && mem_waitrequest;
  assign mem_address    = {alu_result[ADDR_W-1:2], 2'b00};
  assign mem_byteenable = be_s;
  assign addr_error     = addr_error_r;

  // Read sequencing, MDR capture, error flags and write-port hold registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_r        <= IDLE;
      mdr_r        <= 32'd0;
      addr_error_r <= 1'b0;
      bad_load_r   <= 1'b0;
      dest_hold_r  <= 5'd0;
      data_hold_r  <= 32'd0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (issue_s) begin
            if (!mem_waitrequest) begin
              mdr_r <= mem_readdata;
              fsm_r <= VALID;
            end else begin
              fsm_r <= REQ;
            end
          end
        end
        REQ: begin
          if (!mem_waitrequest) begin
            mdr_r <= mem_readdata;
            fsm_r <= VALID;
          end
        end
        VALID: begin
          if (!in_wb_s) begin
            fsm_r <= IDLE;
          end
        end
        default: fsm_r <= IDLE;
      endcase

      if ((state == ST_MEM) && (fsm_r == IDLE) && is_load_s && misaligned_s) begin
        addr_error_r <= 1'b1;
        bad_load_r   <= 1'b1;
      end else if (state == ST_FETCH) begin
        bad_load_r <= 1'b0;
      end

      if (in_wb_s) begin
        dest_hold_r <= wr_dest_s;
        data_hold_r <= wr_data_s;
      end
    end
  end

  // Destination and data selection for every instruction class that writes a register.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_dest_s = dest_hold_r;
    wr_data_s = data_hold_r;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_JR, FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            wr_en_s = 1'b0;
          end
          FN_JALR: begin
            wr_en_s   = 1'b1;
            wr_dest_s = rd_s;
            wr_data_s = link_addr;
          end
          default: begin
            wr_en_s   = 1'b1;
            wr_dest_s = rd_s;
            wr_data_s = alu_result;
          end
        endcase
      end
      OP_REGIMM: begin
        if ((rt_s == 5'b10000) || (rt_s == 5'b10001)) begin
          wr_en_s   = 1'b1;
          wr_dest_s = LINK_R;
          wr_data_s = link_addr;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      OP_JAL: begin
        wr_en_s   = 1'b1;
        wr_dest_s = LINK_R;
        wr_data_s = link_addr;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        wr_en_s   = 1'b1;
        wr_dest_s = rt_s;
        wr_data_s = alu_result;
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        wr_en_s   = 1'b1;
        wr_dest_s = rt_s;
        wr_data_s = align_load(opcode_s, k_s, mdr_r, rt_data);
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  assign RegWrite  = in_wb_s && wr_en_s && (wr_dest_s != 5'd0) && !bad_load_r;
  assign writeR    = in_wb_s ? wr_dest_s : dest_hold_r;
  assign writedata = in_wb_s ? wr_data_s : data_hold_r;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: load expectations go through a scoreboard
// queue and are compared when the write-back stage presents them.
module tb_load_writeback_unit;

  localparam logic [2:0] S_FETCH = 3'b000;
  localparam logic [2:0] S_EXEC  = 3'b010;
  localparam logic [2:0] S_MA    = 3'b011;
  localparam logic [2:0] S_WB    = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [31:0] rt_data;
  logic [31:0] link_addr;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        stall;
  logic        addr_error;
  logic        RegWrite;
  logic [4:0]  writeR;
  logic [31:0] writedata;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_writeback_unit #(.ADDR_W(32), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .state(state), .instr(instr),
    .alu_result(alu_result), .rt_data(rt_data), .link_addr(link_addr),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .mem_read(mem_read), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .stall(stall), .addr_error(addr_error), .RegWrite(RegWrite),
    .writeR(writeR), .writedata(writedata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // One load through MEMORY_ACCESS (with nwait waitrequest cycles), WRITE_BACK and FETCH.
  task automatic do_load(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] rtd, input int nwait,
                         input logic [3:0] be, input logic [31:0] wd);
    int   stalls;
    exp_t e;
    stalls = 0;
    sb_q.push_back('{wr: ins[20:16], wd: wd});
    state           = S_MA;
    instr           = ins;
    alu_result      = addr;
    rt_data         = rtd;
    mem_waitrequest = (nwait > 0);
    mem_readdata    = (nwait > 0) ? 32'h5A5A_5A5A : rdata;
    for (int i = 0; i < nwait; i++) begin
      #1;
      chk({tag, "_rd_wait"}, 32'(mem_read), 32'd1);
      chk({tag, "_addr_wait"}, mem_address, {addr[31:2], 2'b00});
      stalls += int'(stall);
      tick();
      if (i == nwait - 1) begin
        mem_waitrequest = 1'b0;
        mem_readdata    = rdata;
      end
    end
    #1;
    chk({tag, "_rd"}, 32'(mem_read), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_be"}, 32'(mem_byteenable), 32'(be));
    chk({tag, "_addr"}, mem_address, {addr[31:2], 2'b00});
    if (nwait > 0) chk({tag, "_stall_cycles"}, 32'(stalls), 32'(nwait));
    tick();
    state        = S_WB;
    mem_readdata = 32'hC3C3_C3C3;
    #1;
    e = sb_q.pop_front();
    chk({tag, "_rd_wb"}, 32'(mem_read), 32'd0);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'd1);
    chk({tag, "_writeR"}, 32'(writeR), 32'(e.wr));
    chk({tag, "_writedata"}, writedata, e.wd);
    tick();
    state = S_FETCH;
    #1;
    chk({tag, "_regwrite_off"}, 32'(RegWrite), 32'd0);
    chk({tag, "_writedata_hold"}, writedata, e.wd);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; state = S_FETCH; instr = 32'd0; alu_result = 32'd0; rt_data = 32'd0;
    link_addr = 32'd0; mem_readdata = 32'd0; mem_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst_rd", 32'(mem_read), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_aerr", 32'(addr_error), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_writeR", 32'(writeR), 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    reset = 1'b1;
    state = S_EXEC;
    tick();

    do_load("lw",     enc_i(6'b100011, 5'd8,  16'h0), 32'h100, 32'hDEAD_BEEF, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",     enc_i(6'b100000, 5'd9,  16'h0), 32'h103, 32'h8011_2233, 32'h0,         0, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu",    enc_i(6'b100100, 5'd10, 16'h0), 32'h103, 32'h8011_2233, 32'h0,         0, 4'b1000, 32'h0000_0080);
    do_load("lwl_k1", enc_i(6'b100010, 5'd11, 16'h0), 32'h101, 32'hAABB_CCDD, 32'h1122_3344, 0, 4'b1111, 32'hCCDD_3344);
    do_load("lwr_k2", enc_i(6'b100110, 5'd12, 16'h0), 32'h102, 32'hAABB_CCDD, 32'h1122_3344, 0, 4'b1111, 32'h1122_AABB);
    do_load("lh_w3",  enc_i(6'b100001, 5'd13, 16'h0), 32'h102, 32'h8001_7FFF, 32'h0,         3, 4'b1100, 32'hFFFF_8001);
    do_load("lhu_w1", enc_i(6'b100101, 5'd14, 16'h0), 32'h100, 32'h1234_9ABC, 32'h0,         1, 4'b0011, 32'h0000_9ABC);
    do_load("lwl_k3", enc_i(6'b100010, 5'd16, 16'h0), 32'h103, 32'hAABB_CCDD, 32'h1122_3344, 0, 4'b1111, 32'hAABB_CCDD);
    do_load("lwr_k0", enc_i(6'b100110, 5'd17, 16'h0), 32'h100, 32'h0102_0304, 32'h1122_3344, 0, 4'b1111, 32'h0102_0304);

    // Non-load in MEMORY_ACCESS must leave the MDR alone.
    state = S_MA; instr = {6'b000000, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100001};
    alu_result = 32'h100; mem_readdata = 32'h1234_5678;
    #1;
    chk("nonload_rd", 32'(mem_read), 32'd0);
    tick();
    state = S_WB; instr = enc_i(6'b100011, 5'd15, 16'h0);
    #1;
    chk("mdr_keep", writedata, 32'h0102_0304);
    chk("mdr_keep_writeR", 32'(writeR), 32'd15);
    tick();

    instr = {6'b000000, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100001}; alu_result = 32'h77; #1;
    chk("addu_regwrite", 32'(RegWrite), 32'd1);
    chk("addu_writeR", 32'(writeR), 32'd5);
    chk("addu_writedata", writedata, 32'h77);
    tick();
    instr = {6'b000011, 26'h10}; link_addr = 32'h0040_0008; #1;
    chk("jal_regwrite", 32'(RegWrite), 32'd1);
    chk("jal_writeR", 32'(writeR), 32'd31);
    chk("jal_writedata", writedata, 32'h0040_0008);
    tick();
    instr = {6'b000001, 5'd4, 5'b10001, 16'h4}; link_addr = 32'h0040_0010; #1;
    chk("bgezal_writeR", 32'(writeR), 32'd31);
    chk("bgezal_writedata", writedata, 32'h0040_0010);
    tick();
    instr = enc_i(6'b001001, 5'd0, 16'h5); alu_result = 32'h99; #1;
    chk("addiu_r0_regwrite", 32'(RegWrite), 32'd0);
    tick();
    instr = enc_i(6'b001101, 5'd6, 16'h5); alu_result = 32'hABCD; #1;
    chk("ori_regwrite", 32'(RegWrite), 32'd1);
    chk("ori_writeR", 32'(writeR), 32'd6);
    chk("ori_writedata", writedata, 32'hABCD);
    tick();
    instr = enc_i(6'b101011, 5'd7, 16'h0); #1;
    chk("sw_regwrite", 32'(RegWrite), 32'd0);
    tick();
    state = S_FETCH; tick();

    // Misaligned LW: no read, sticky error, no register write.
    state = S_MA; instr = enc_i(6'b100011, 5'd7, 16'h0); alu_result = 32'h102; mem_waitrequest = 1'b0;
    #1;
    chk("mis_rd", 32'(mem_read), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    chk("mis_aerr", 32'(addr_error), 32'd1);
    state = S_WB; #1;
    chk("mis_regwrite", 32'(RegWrite), 32'd0);
    tick();
    state = S_FETCH; tick();
    chk("mis_aerr_sticky", 32'(addr_error), 32'd1);

    // Reset in the middle of a waiting read.
    state = S_MA; instr = enc_i(6'b100011, 5'd8, 16'h0); alu_result = 32'h200;
    mem_waitrequest = 1'b1; mem_readdata = 32'h9999_9999;
    #1;
    chk("req_rd", 32'(mem_read), 32'd1);
    chk("req_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1; state = S_FETCH; mem_waitrequest = 1'b0;
    #1;
    chk("mrst_rd", 32'(mem_read), 32'd0);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_aerr", 32'(addr_error), 32'd0);
    chk("mrst_regwrite", 32'(RegWrite), 32'd0);
    chk("mrst_writeR", 32'(writeR), 32'd0);
    chk("mrst_writedata", writedata, 32'd0);
    tick();
    state = S_WB; instr = enc_i(6'b100011, 5'd3, 16'h0); alu_result = 32'h100; #1;
    chk("mrst_mdr_zero", writedata, 32'd0);
    tick();
    state = S_FETCH; tick();
    do_load("lw_after_rst", enc_i(6'b100011, 5'd4, 16'h0), 32'h104, 32'h0BAD_F00D, 32'h0, 2, 4'b1111, 32'h0BAD_F00D);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
